// File: rtl/ibex_pkg.sv
// Shared types for the instruction-bus responder: the queued response entry
// and the grant-stall LFSR feedback taps.
package ibex_pkg;

  localparam int unsigned CdW = 3;

  // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting toward the MSB.
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  typedef struct packed {
    logic [31:0]    data;
    logic           err;
    logic [CdW-1:0] cd;
  } rsp_entry_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/ibex_instr_rsp_fifo.sv
// In-order response queue; every entry ages its countdown each cycle and the
// head is offered once its countdown has reached zero.
module ibex_instr_rsp_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned  Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  rsp_entry_t      push_entry_i,
  input  logic            pop_i,
  output logic [CntW-1:0] count_o,
  output logic            head_ready_o,
  output logic [31:0]     head_data_o,
  output logic            head_err_o
);

  rsp_entry_t [Depth-1:0] entries_q, entries_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [CntW-1:0]        fill_idx;
  logic                   pop_eff;

  assign pop_eff  = pop_i & (count_q != '0);
  assign fill_idx = count_q - CntW'(pop_eff);

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < Depth; i++) begin
      if (entries_q[i].cd != '0) begin
        entries_d[i].cd = entries_q[i].cd - CdW'(1);
      end
    end
    // Head leaves by shifting everything one slot toward index 0.
    if (pop_eff) begin
      for (int i = 0; i < Depth - 1; i++) begin
        entries_d[i] = entries_d[i+1];
      end
      entries_d[Depth-1] = '0;
    end
    if (push_i) begin
      for (int i = 0; i < Depth; i++) begin
        if (CntW'(i) == fill_idx) begin
          entries_d[i] = push_entry_i;
        end
      end
    end
  end

  assign count_d = count_q + CntW'(push_i) - CntW'(pop_eff);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entries_q <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_ready_o = (count_q != '0) && (entries_q[0].cd == '0);
  assign head_data_o  = entries_q[0].data;
  assign head_err_o   = entries_q[0].err;

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Instruction-bus memory responder: preloadable word store, grant with
// optional pseudo-random stalls, fixed-latency in-order responses.
module ibex_instr_bus_responder
  import ibex_pkg::*;
#(
  parameter logic [31:0]  BaseAddr       = 32'h0000_0000,
  parameter int unsigned  MemWords       = 1024,
  parameter int unsigned  Latency        = 1,
  parameter int unsigned  MaxOutstanding = 2,
  parameter bit           GntStallEn     = 1'b0,
  parameter logic [7:0]   LfsrSeed       = 8'hA5,
  localparam int unsigned AddrW          = $clog2(MemWords),
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             load_we_i,
  input  logic [AddrW-1:0] load_addr_i,
  input  logic [31:0]      load_data_i,
  output logic             busy_o
);

  localparam logic [32:0] LoBound = {1'b0, BaseAddr};
  localparam logic [32:0] HiBound = LoBound + (33'(MemWords) << 2);

  logic [31:0]      mem_q [MemWords];
  logic [32:0]      addr_ext;
  logic [31:0]      offset;
  logic [AddrW-1:0] word_idx;
  logic             in_range;
  logic             stall;
  logic             gnt;
  logic             rvalid;
  rsp_entry_t       push_entry;
  logic [CntW-1:0]  count;
  logic             head_ready;
  logic [31:0]      head_data;
  logic             head_err;

  // Not reset: preload is expected to happen while the core is held in reset.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  if (GntStallEn) begin : g_stall
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
      lfsr_d = lfsr_q;
      if (instr_req_i) begin
        lfsr_d = lfsr_step(lfsr_q);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        lfsr_q <= LfsrSeed;
      end else begin
        lfsr_q <= lfsr_d;
      end
    end

    assign stall = lfsr_q[0];
  end else begin : g_no_stall
    assign stall = 1'b0;
  end

  // 33-bit compare so a window touching 2^32 does not wrap.
  assign addr_ext = {1'b0, instr_addr_i[31:2], 2'b00};
  assign in_range = (addr_ext >= LoBound) && (addr_ext < HiBound);
  assign offset   = instr_addr_i - BaseAddr;
  assign word_idx = AddrW'(offset >> 2);

  always_comb begin
    push_entry      = '0;
    push_entry.err  = ~in_range;
    push_entry.data = in_range ? mem_q[word_idx] : 32'h0;
    push_entry.cd   = CdW'(Latency - 1);
  end

  // Full blocks the grant even when the head retires this cycle.
  assign gnt = instr_req_i & ~rst_i & ~stall & (count < CntW'(MaxOutstanding));

  ibex_instr_rsp_fifo #(
    .Depth (MaxOutstanding)
  ) u_rsp_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (gnt),
    .push_entry_i (push_entry),
    .pop_i        (rvalid),
    .count_o      (count),
    .head_ready_o (head_ready),
    .head_data_o  (head_data),
    .head_err_o   (head_err)
  );

  assign rvalid = head_ready & ~rst_i;

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? head_data : 32'h0;
  assign instr_err_o    = rvalid & head_err;
  assign busy_o         = ~rst_i & ((count != '0) | rvalid);

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Three responder configurations checked against a due-time queue model,
// plus directed scenarios with literal expectations.
module tb_ibex_instr_bus_responder;

  localparam int N  = 3;
  localparam int MW = 64;
  localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'hFFFF_FF00, 32'h0000_0100};
  localparam int LAT  [N] = '{1, 3, 2};
  localparam int MOUT [N] = '{2, 2, 3};
  localparam bit STL  [N] = '{1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst    [N];
  logic        req    [N];
  logic [31:0] addr   [N];
  logic        gnt    [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        err    [N];
  logic        busy   [N];
  logic        lwe    [N];
  logic [5:0]  laddr  [N];
  logic [31:0] ldata  [N];

  always #5 clk = ~clk;

  ibex_instr_bus_responder #(
    .BaseAddr(32'h0000_0000), .MemWords(MW), .Latency(1), .MaxOutstanding(2),
    .GntStallEn(1'b0), .LfsrSeed(8'hA5)
  ) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
    .instr_err_o(err[0]), .load_we_i(lwe[0]), .load_addr_i(laddr[0]),
    .load_data_i(ldata[0]), .busy_o(busy[0])
  );

  ibex_instr_bus_responder #(
    .BaseAddr(32'hFFFF_FF00), .MemWords(MW), .Latency(3), .MaxOutstanding(2),
    .GntStallEn(1'b0), .LfsrSeed(8'hA5)
  ) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
    .instr_err_o(err[1]), .load_we_i(lwe[1]), .load_addr_i(laddr[1]),
    .load_data_i(ldata[1]), .busy_o(busy[1])
  );

  ibex_instr_bus_responder #(
    .BaseAddr(32'h0000_0100), .MemWords(MW), .Latency(2), .MaxOutstanding(3),
    .GntStallEn(1'b1), .LfsrSeed(8'hA5)
  ) dut2 (
    .clk_i(clk), .rst_i(rst[2]), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
    .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]),
    .instr_err_o(err[2]), .load_we_i(lwe[2]), .load_addr_i(laddr[2]),
    .load_data_i(ldata[2]), .busy_o(busy[2])
  );

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        mq [N][$];
  logic [31:0] mm [N][MW];
  logic [7:0]  ml [N];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat(input int i, input int w);
    if (i == 0 && w == 0) return 32'h0000_0013;
    return 32'hC0DE_0000 | 32'(i << 8) | 32'(w);
  endfunction

  // Reference model: a response is due exactly LAT cycles after its grant.
  always @(negedge clk) begin : model
    bit          stall_m, erv, eg;
    longint      a, b;
    exp_t        ne;
    for (int i = 0; i < N; i++) begin
      if (rst[i]) begin
        chk($sformatf("i%0d_rst_gnt", i), 32'(gnt[i]), 0);
        chk($sformatf("i%0d_rst_rvalid", i), 32'(rvalid[i]), 0);
        chk($sformatf("i%0d_rst_rdata", i), rdata[i], 0);
        chk($sformatf("i%0d_rst_err", i), 32'(err[i]), 0);
        chk($sformatf("i%0d_rst_busy", i), 32'(busy[i]), 0);
        mq[i].delete();
        ml[i] = 8'hA5;
      end else begin
        stall_m = STL[i] && ml[i][0];
        erv = (mq[i].size() > 0) && (mq[i][0].due == cyc);
        eg  = req[i] && (mq[i].size() < MOUT[i]) && !stall_m;
        chk($sformatf("i%0d_gnt", i), 32'(gnt[i]), 32'(eg));
        chk($sformatf("i%0d_rvalid", i), 32'(rvalid[i]), 32'(erv));
        chk($sformatf("i%0d_rdata", i), rdata[i], erv ? mq[i][0].d : 32'h0);
        chk($sformatf("i%0d_err", i), 32'(err[i]), erv ? 32'(mq[i][0].e) : 32'h0);
        chk($sformatf("i%0d_busy", i), 32'(busy[i]), 32'(mq[i].size() != 0));
        if (erv) void'(mq[i].pop_front());
        if (eg) begin
          a = longint'({addr[i][31:2], 2'b00});
          b = longint'(BASE[i]);
          ne.due = cyc + LAT[i];
          if (a >= b && a < b + 4 * MW) begin
            ne.d = mm[i][int'((a - b) >> 2)];
            ne.e = 1'b0;
          end else begin
            ne.d = 32'h0;
            ne.e = 1'b1;
          end
          mq[i].push_back(ne);
        end
        if (req[i]) ml[i] = {ml[i][6:0], ml[i][7] ^ ml[i][5] ^ ml[i][4] ^ ml[i][3]};
      end
      if (lwe[i]) mm[i][laddr[i]] = ldata[i];
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_one(input int i, input logic [31:0] a,
                         output logic [31:0] d, output logic e);
    bit g;
    req[i]  = 1'b1;
    addr[i] = a;
    g = 1'b0;
    for (int t = 0; t < 100 && !g; t++) begin
      @(negedge clk);
      g = gnt[i];
      step();
    end
    req[i] = 1'b0;
    chk($sformatf("i%0d_gnt_seen_%h", i, a), 32'(g), 1);
    d = 32'h0;
    e = 1'b0;
    g = 1'b0;
    for (int t = 0; t < 20 && !g; t++) begin
      @(negedge clk);
      if (rvalid[i]) begin
        g = 1'b1;
        d = rdata[i];
        e = err[i];
      end
      step();
    end
    chk($sformatf("i%0d_rvalid_seen_%h", i, a), 32'(g), 1);
  endtask

  initial begin : stim
    logic [31:0] d;
    logic        e;
    logic [3:0]  gv;
    int          ng, nr, k;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; addr[i] = 32'h0;
      lwe[i] = 1'b0; laddr[i] = '0; ldata[i] = 32'h0;
    end
    step();
    // Preload every word while held in reset.
    for (int w = 0; w < MW; w++) begin
      for (int i = 0; i < N; i++) begin
        lwe[i] = 1'b1; laddr[i] = 6'(w); ldata[i] = pat(i, w);
      end
      step();
    end
    for (int i = 0; i < N; i++) lwe[i] = 1'b0;
    @(negedge clk);
    chk("reset_busy0", 32'(busy[0]), 0);
    chk("reset_rvalid1", 32'(rvalid[1]), 0);
    step();
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    step();

    // First fetch: grant same cycle, data the next.
    req[0] = 1'b1; addr[0] = 32'h0;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt[0]), 1);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_rvalid", 32'(rvalid[0]), 1);
    chk("t1_rdata", rdata[0], 32'h0000_0013);
    chk("t1_err", 32'(err[0]), 0);
    step();

    // Window edges.
    req_one(0, 32'h0000_0100, d, e);
    chk("t2_oor_rdata", d, 32'h0);
    chk("t2_oor_err", 32'(e), 1);
    req_one(0, 32'h0000_00FE, d, e);
    chk("t2_last_rdata", d, 32'hC0DE_003F);
    chk("t2_last_err", 32'(e), 0);

    // Same-cycle preload to the granted word returns the old value.
    req[0] = 1'b1; addr[0] = 32'h8;
    lwe[0] = 1'b1; laddr[0] = 6'd2; ldata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_gnt", 32'(gnt[0]), 1);
    step();
    req[0] = 1'b0; lwe[0] = 1'b0;
    @(negedge clk);
    chk("t3_old_data", rdata[0], 32'hC0DE_0002);
    step();
    req_one(0, 32'h8, d, e);
    chk("t3_new_data", d, 32'hDEAD_BEEF);

    // Sixteen back-to-back fetches.
    ng = 0; nr = 0;
    for (int c = 0; c < 17; c++) begin
      req[0] = (c < 16); addr[0] = 32'(4 * c);
      @(negedge clk);
      if (c == 0) chk("t4_first_rvalid", 32'(rvalid[0]), 0);
      ng += int'(gnt[0]);
      nr += int'(rvalid[0]);
      step();
    end
    req[0] = 1'b0;
    chk("t4_gnt_count", 32'(ng), 16);
    chk("t4_rvalid_count", 32'(nr), 16);

    // Latency 3, depth 2: only two grants before the queue frees up.
    req[1] = 1'b1; addr[1] = 32'hFFFF_FF04;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      gv[3-c] = gnt[1];
      step();
    end
    req[1] = 1'b0;
    chk("t5_gnt_pattern", 32'(gv), 32'b1100);
    for (int t = 0; t < 10 && busy[1]; t++) step();
    @(negedge clk);
    chk("t5_drained", 32'(busy[1]), 0);
    step();

    req_one(1, 32'hFFFF_FFFC, d, e);
    chk("t6_top_rdata", d, 32'hC0DE_013F);
    chk("t6_top_err", 32'(e), 0);
    req_one(1, 32'hFFFF_FEFC, d, e);
    chk("t6_below_err", 32'(e), 1);
    req_one(1, 32'h0000_0000, d, e);
    chk("t6_wrap_err", 32'(e), 1);
    chk("t6_wrap_rdata", d, 32'h0);

    // Reset with two responses pending.
    req[1] = 1'b1; addr[1] = 32'hFFFF_FF08;
    @(negedge clk); step();
    @(negedge clk); step();
    req[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk); step();
    rst[1] = 1'b0;
    @(negedge clk);
    chk("t7_rvalid_after_rst", 32'(rvalid[1]), 0);
    chk("t7_busy_after_rst", 32'(busy[1]), 0);
    step();
    req_one(1, 32'hFFFF_FF08, d, e);
    chk("t7_post_rst_rdata", d, 32'hC0DE_0102);

    // Stalled grants: 200 requests, occasionally withdrawn before grant.
    k = 0; nr = 0;
    for (int t = 0; t < 3000 && (k < 200 || busy[2]); t++) begin
      req[2] = (k < 200) && (t % 7 != 3);
      if (k % 9 == 8)        addr[2] = 32'h0000_0000;
      else if (k % 13 == 12) addr[2] = 32'h0000_0200;
      else                   addr[2] = 32'h0000_0100 + 32'(4 * (k % MW));
      @(negedge clk);
      if (gnt[2]) k++;
      if (rvalid[2]) nr++;
      step();
    end
    req[2] = 1'b0;
    chk("t8_grants", 32'(k), 200);
    chk("t8_responses", 32'(nr), 200);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ibex_instr_bus_responder.md
IBEX_INSTR_BUS_RESPONDER -- requirements
Module: ibex_instr_bus_responder

Interface
REQ-001 Parameter BaseAddr, 32'h0000_0000, byte address of word 0 of the backing store.
REQ-002 Parameter MemWords, 1024, number of 32-bit words in the store (power of two, 16..65536).
REQ-003 Parameter Latency, 1, cycles from grant to rvalid (1..8).
REQ-004 Parameter MaxOutstanding, 2, accepted but unanswered requests (1..4).
REQ-005 Parameter GntStallEn, 1'b0, enables pseudo-random grant stalls.
REQ-006 Parameter LfsrSeed, 8'hA5, stall LFSR reset value (nonzero).
REQ-007 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 instr_req_i  in  1  initiator request.
REQ-010 instr_addr_i  in  32  request byte address.
REQ-011 instr_gnt_o  out  1  request accepted this cycle.
REQ-012 instr_rvalid_o  out  1  response valid this cycle.
REQ-013 instr_rdata_o  out  32  response data.
REQ-014 instr_err_o  out  1  response error, valid with rvalid.
REQ-015 load_we_i  in  1  preload write strobe.
REQ-016 load_addr_i  in  log2(MemWords)  preload word index.
REQ-017 load_data_i  in  32  preload data.
REQ-018 busy_o  out  1  one or more requests outstanding.

Function
REQ-019 Grant: instr_gnt_o = instr_req_i & ~rst_i & (count < MaxOutstanding) & ~stall, combinational; a grant completes the address phase.
REQ-020 stall is 0 when GntStallEn=0; else LFSR bit 0 (x^8+x^6+x^5+x^4+1), LFSR advancing every cycle instr_req_i=1.
REQ-021 On grant, address checked: in range iff BaseAddr <= addr < BaseAddr+4*MemWords (33-bit compare, no wrap); addr[1:0] ignored.
REQ-022 On grant, an entry {data, err, countdown=Latency-1} is pushed to a MaxOutstanding-deep in-order queue; data is the store word read that cycle, err=~in_range, data=0 when err.
REQ-023 Countdowns of all non-head-ready entries decrement each cycle, saturating at 0.
REQ-024 instr_rvalid_o is registered: asserted the cycle after head entry countdown is 0; first rvalid exactly Latency cycles after the grant cycle.
REQ-025 Responses strictly in grant order; at most one rvalid per cycle; an entry retires in its rvalid cycle.
REQ-026 Back-to-back: with Latency=1, MaxOutstanding>=2, no stall, sustained one grant and one rvalid per cycle.
REQ-027 Full: count==MaxOutstanding blocks grant even if a retire occurs the same cycle (no bypass).
REQ-028 Simultaneous push and retire leave count unchanged.
REQ-029 instr_rdata_o and instr_err_o are 0 whenever instr_rvalid_o=0.
REQ-030 Preload write takes effect next cycle; same-cycle grant to the same word returns old data; already-queued entries unaffected.
REQ-031 busy_o = (count != 0) | instr_rvalid_o.
REQ-032 Request dropped before grant is legal and leaves no state.

Reset
REQ-033 While rst_i=1: gnt 0, rvalid 0, rdata 0, err 0, busy 0, queue emptied, LFSR=LfsrSeed; reset mid-transaction discards pending responses.
REQ-034 Store contents are not reset; preload writes honoured during reset.

Structure
REQ-035 Response-entry struct and LFSR tap constant belong in ibex_pkg.
REQ-036 Queue is a sub-module ibex_instr_rsp_fifo (push/pop/count/head); store and grant logic in top.

Verification
REQ-037 Preload word 0=32'h0000_0013; req addr BaseAddr, Latency=1 -> gnt same cycle, rvalid next cycle, rdata 32'h0000_0013, err 0.
REQ-038 Req addr BaseAddr+4*MemWords -> granted, rvalid after Latency, err 1, rdata 0.
REQ-039 MaxOutstanding=2, Latency=3, req held 4 cycles -> gnt on cycles 0,1 only, blocked until first retire, responses in order.
REQ-040 Latency=1, continuous req to incrementing addresses for 16 cycles -> 16 gnts, 16 rvalids, 1 cycle offset.
REQ-041 rst_i asserted with 2 outstanding -> next cycle rvalid 0, busy 0; post-reset request answered normally.
REQ-042 GntStallEn=1, 200 requests -> every request eventually granted, all responses correct and ordered.
